fp_result_checker: RTL

- Synthesizable, parametrised scoreboard for the fp_unit result stream.
- Expected results (result, flags, fmt, NaN-relax qualifier, last marker) are pushed into an internal FIFO ahead of the DUT.
- Each DUT result beat (fp_exe_o.ready) pops one entry and compares it. The check is therefore independent of fp_unit latency, including variable-latency fdiv/fsqrt.
- Accumulates pass/fail counts, captures the first mismatch, and reports done/failed status to the bench or an on-chip test harness.

---
 rtl/fp_result_checker.sv | 345 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_result_checker.sv
// ---------------------------------------------------------------------------
// fp_result_checker
//
// Purpose:
//   Latency-independent scoreboard for the fp_unit result stream. Expected
//   results are queued in a small FIFO ahead of the unit under test. Every
//   DUT result beat pops the head entry and the comparison outcome is
//   registered into pass/fail counters and a first-mismatch capture.
//   Because entries are matched by order, not by time, variable-latency
//   operations (fdiv/fsqrt) need no special handling.
//
// Optional feature:
//   FP_CHECK_TIMEOUT_EN - when defined, a watchdog forces FAIL if the FIFO
//   holds entries but no DUT beat arrives for TIMEOUT consecutive cycles,
//   and the extra sticky output 'timeout' is present.
//
// Ports:
//   clock, reset        clock; synchronous active-low reset
//   exp_valid/exp_ready expected-entry handshake
//   exp_result          expected result (XLEN bits)
//   exp_flags           expected fflags {NV,DZ,OF,UF,NX}
//   exp_fmt             0 = single, 1 = double
//   exp_nan_relax       canonical-NaN payload relaxation allowed
//   exp_last            entry is the final vector
//   dut_valid           DUT result strobe (one beat per result)
//   dut_result          DUT result
//   dut_flags           DUT flags
//   pass_count          matched comparisons (saturating)
//   fail_count          mismatched comparisons (saturating)
//   err_valid           first-mismatch capture valid (sticky)
//   err_exp_result/err_got_result/err_exp_flags/err_got_flags
//                       captured values of the first mismatch
//   orphan              sticky; a DUT beat arrived with the FIFO empty
//   done                sticky; the last entry has been compared
//   failed              sticky; any mismatch, orphan or timeout
//   timeout             (FP_CHECK_TIMEOUT_EN only) sticky watchdog expiry
// ---------------------------------------------------------------------------
module fp_result_checker #(
    parameter int XLEN         = 64,
    parameter int DEPTH        = 8,
    parameter int CNT_W        = 32,
    parameter int STOP_ON_FAIL = 1,
    parameter int TIMEOUT      = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [XLEN-1:0]  exp_result,
    input  logic [4:0]       exp_flags,
    input  logic [1:0]       exp_fmt,
    input  logic             exp_nan_relax,
    input  logic             exp_last,
    input  logic             dut_valid,
    input  logic [XLEN-1:0]  dut_result,
    input  logic [4:0]       dut_flags,
    output logic [CNT_W-1:0] pass_count,
    output logic [CNT_W-1:0] fail_count,
    output logic             err_valid,
    output logic [XLEN-1:0]  err_exp_result,
    output logic [XLEN-1:0]  err_got_result,
    output logic [4:0]       err_exp_flags,
    output logic [4:0]       err_got_flags,
    output logic             orphan,
    output logic             done,
    output logic             failed
`ifdef FP_CHECK_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [4:0]      flags;
        logic [1:0]      fmt;
        logic            relax;
        logic            last;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_valid_q, err_valid_d;
    logic [XLEN-1:0]  err_exp_result_q, err_exp_result_d;
    logic [XLEN-1:0]  err_got_result_q, err_got_result_d;
    logic [4:0]       err_exp_flags_q, err_exp_flags_d;
    logic [4:0]       err_got_flags_q, err_got_flags_d;
    logic             orphan_q, orphan_d;
    logic             done_q, done_d;
    logic             failed_q, failed_d;

`ifdef FP_CHECK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             timeout_q, timeout_d;
    logic             wd_run;
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // Handshake and FIFO status (all from registered state)
    // ------------------------------------------------------------------
    logic   active, empty, full;
    logic   push, beat, pop, orphan_hit;
    entry_t head, push_entry;

    assign active     = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign empty      = (count_q == '0);
    assign full       = (count_q == OW'(DEPTH));
    assign exp_ready  = active && !full;
    assign push       = exp_valid && exp_ready;
    assign beat       = dut_valid && active;
    // A beat is only matched against entries already stored; a same-cycle
    // push into an empty FIFO does not rescue it.
    assign orphan_hit = beat && empty;
    assign pop        = beat && !empty;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        push_entry        = '0;
        push_entry.result = exp_result;
        push_entry.flags  = exp_flags;
        push_entry.fmt    = exp_fmt;
        push_entry.relax  = exp_nan_relax;
        push_entry.last   = exp_last;
    end

    // ------------------------------------------------------------------
    // Comparison mask. When relaxation is allowed and the DUT produced the
    // canonical NaN of the entry's format, only the exponent and quiet bit
    // are compared so any expected NaN payload is accepted.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] mask_single, mask_double, cmp_mask;
    logic            is_snan, is_dnan, mismatch;

    for (genvar gi = 0; gi < XLEN; gi++) begin : g_mask
        assign mask_single[gi] = (gi >= 22) && (gi <= 30);
        assign mask_double[gi] = (gi >= 51) && (gi <= 62);
    end

    assign is_snan = (dut_result[31:0] == 32'h7FC0_0000);

    if (XLEN >= 64) begin : g_dnan
        assign is_dnan = (dut_result[63:0] == 64'h7FF8_0000_0000_0000);
    end else begin : g_no_dnan
        assign is_dnan = 1'b0;
    end

    always_comb begin
        cmp_mask = '1;
        if (head.relax && (head.fmt == 2'd0) && is_snan) begin
            cmp_mask = mask_single;
        end else if (head.relax && (head.fmt == 2'd1) && is_dnan) begin
            cmp_mask = mask_double;
        end
    end

    assign mismatch = pop && ((((head.result ^ dut_result) & cmp_mask) != '0) ||
                              (head.flags != dut_flags));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        rd_ptr_d         = rd_ptr_q;
        count_d          = count_q;
        pass_d           = pass_q;
        fail_d           = fail_q;
        err_valid_d      = err_valid_q;
        err_exp_result_d = err_exp_result_q;
        err_got_result_d = err_got_result_q;
        err_exp_flags_d  = err_exp_flags_q;
        err_got_flags_d  = err_got_flags_q;
        orphan_d         = orphan_q;
        done_d           = done_q;
        failed_d         = failed_q;
`ifdef FP_CHECK_TIMEOUT_EN
        wd_d             = wd_q;
        timeout_d        = timeout_q;
`endif

        // FIFO bookkeeping; pointers wrap naturally at a power-of-two depth.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + OW'(push) - OW'(pop);

        // Registered comparison outcome.
        if (pop && !mismatch && (pass_q != {CNT_W{1'b1}})) begin
            pass_d = pass_q + CNT_W'(1);
        end
        if (mismatch) begin
            if (fail_q != {CNT_W{1'b1}}) begin
                fail_d = fail_q + CNT_W'(1);
            end
            failed_d = 1'b1;
            if (!err_valid_q) begin
                err_valid_d      = 1'b1;
                err_exp_result_d = head.result;
                err_got_result_d = dut_result;
                err_exp_flags_d  = head.flags;
                err_got_flags_d  = dut_flags;
            end
        end
        if (orphan_hit) begin
            orphan_d = 1'b1;
            failed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (orphan_hit) begin
                    state_d = ST_FAIL;
                end else if (push) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (orphan_hit) begin
                    state_d = ST_FAIL;
                end else if (mismatch && (STOP_ON_FAIL != 0)) begin
                    state_d = ST_FAIL;
                end else if (pop && head.last) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // DONE and FAIL hold until reset; nothing is accepted.
            end
        endcase

`ifdef FP_CHECK_TIMEOUT_EN
        // Counts cycles where work is outstanding but the DUT is silent.
        if (wd_run) begin
            wd_d = wd_q + WD_W'(1);
            if (wd_q == WD_W'(TIMEOUT - 1)) begin
                timeout_d = 1'b1;
                failed_d  = 1'b1;
                state_d   = ST_FAIL;
            end
        end else begin
            wd_d = '0;
        end
`endif

        if (!reset) begin
            state_d          = ST_IDLE;
            wr_ptr_d         = '0;
            rd_ptr_d         = '0;
            count_d          = '0;
            pass_d           = '0;
            fail_d           = '0;
            err_valid_d      = 1'b0;
            err_exp_result_d = '0;
            err_got_result_d = '0;
            err_exp_flags_d  = '0;
            err_got_flags_d  = '0;
            orphan_d         = 1'b0;
            done_d           = 1'b0;
            failed_d         = 1'b0;
`ifdef FP_CHECK_TIMEOUT_EN
            wd_d             = '0;
            timeout_d        = 1'b0;
`endif
        end
    end

`ifdef FP_CHECK_TIMEOUT_EN
    assign wd_run = (state_q == ST_RUN) && !empty && !dut_valid;
`endif

    // ------------------------------------------------------------------
    // State registers (reset folded into the _d logic above)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        state_q          <= state_d;
        wr_ptr_q         <= wr_ptr_d;
        rd_ptr_q         <= rd_ptr_d;
        count_q          <= count_d;
        pass_q           <= pass_d;
        fail_q           <= fail_d;
        err_valid_q      <= err_valid_d;
        err_exp_result_q <= err_exp_result_d;
        err_got_result_q <= err_got_result_d;
        err_exp_flags_q  <= err_exp_flags_d;
        err_got_flags_q  <= err_got_flags_d;
        orphan_q         <= orphan_d;
        done_q           <= done_d;
        failed_q         <= failed_d;
`ifdef FP_CHECK_TIMEOUT_EN
        wd_q             <= wd_d;
        timeout_q        <= timeout_d;
`endif
    end

    // Entry storage; contents need no reset because the pointers do.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pass_count     = pass_q;
    assign fail_count     = fail_q;
    assign err_valid      = err_valid_q;
    assign err_exp_result = err_exp_result_q;
    assign err_got_result = err_got_result_q;
    assign err_exp_flags  = err_exp_flags_q;
    assign err_got_flags  = err_got_flags_q;
    assign orphan         = orphan_q;
    assign done           = done_q;
    assign failed         = failed_q;
`ifdef FP_CHECK_TIMEOUT_EN
    assign timeout        = timeout_q;
`endif

endmodule
